mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  E-stage multi-cycle multiply/divide unit owning the HI/LO registers.
//  Executes mult/multu/div/divu over a fixed cycle count, and mthi/mtlo/mfhi/mflo in a single cycle.
//  Drives busy back to the hazard logic. The hazard logic stalls D-stage md/mt/mf instructions on (busy | start).
//  Sits beside the ALU; mdu_out joins the E-stage result mux.
// PARAMETERS
//  MULT_CYCLES  5   busy duration for mult/multu
//  DIV_CYCLES   10  busy duration for div/divu
//  CNT_W        4   counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
// PORTS
//  clk      in   1   system clock
//  reset    in   1   synchronous, active-high reset
//  start    in   1   E-stage instr is mult/multu/div/divu (decoded by controller)
//  mdu_op   in   3   op code, defined in the shared header
//  rs_val   in   32  forwarded rs operand
//  rt_val   in   32  forwarded rt operand
//  req      in   1   exception/interrupt taken this cycle; cancels the E-stage MDU instr
//  busy     out  1   operation in flight
//  hi       out  32  architectural HI
//  lo       out  32  architectural LO
//  mdu_out  out  32  mfhi -> hi, otherwise lo (combinational)
// BEHAVIOUR
//  - Reset, at the next rising edge: busy=0, hi=0, lo=0, counter=0, internal result regs=0.
//  - Reset overrides everything, including an operation in flight.
//  - Launch: start & !busy & !req at edge T.
//      - Operands latched; counter loaded with MULT_CYCLES or DIV_CYCLES.
//      - busy=1 from T+1 until the counter reaches 0.
//      - Result committed to hi/lo at the edge where the counter goes 1->0; busy reads 0 in that same cycle.
//      - mult: busy for exactly MULT_CYCLES cycles after T.
//  - While busy, hi/lo hold their old values. The result is held in private regs until commit.
//  - mult/multu: {hi,lo} = 64-bit signed/unsigned product of rs_val, rt_val.
//  - div/divu: lo = quotient, hi = remainder.
//      - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
//  - Divide by zero (rt_val==0): full DIV_CYCLES busy; hi/lo unchanged at commit.
//  - mthi/mtlo: with !busy & !req, write rs_val to hi/lo at the next edge; no busy.
//  - mfhi/mflo: pure read through mdu_out; no state change.
//  - req=1 blocks launch and mthi/mtlo in that cycle.
//      - An already-running operation is NOT cancelled; it belongs to an older, committed instr.
//  - start or mt while busy: ignored, state unchanged. The hazard unit makes this unreachable; the bench asserts on it.
//  - Simultaneous commit and mthi/mtlo: unreachable for the same reason; if it occurs, commit wins.
//  - No combinational path from start/req to busy; busy is a pure register decode.
// STRUCTURE
//  - Shared header (alongside the controller defines): MDU op codes.
//      - MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO, MDU_NONE.
//  - Sub-module mdu_arith: combinational 64-bit product and quotient/remainder from latched operands + op.
//  - mult_div_unit keeps the counter, busy, result regs, hi/lo and the mdu_out mux.
// TESTING
//  1. rs=0xFFFFFFFD, rt=5, MULT, start.
//     -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. DIVU 7/2 -> busy for 10 cycles; lo=3, hi=1.
//     DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3. MTHI rs=0x00001234 -> hi=0x1234 after 1 edge; busy stays 0.
//     Next cycle MFHI -> mdu_out=0x1234.
//  4. MULT with req=1 -> busy stays 0; hi/lo unchanged.
//     MULT at T, req=1 at T+2 -> completes normally at T+5.
//  5. DIV running, reset=1 at its 3rd busy cycle -> next edge busy=0, hi=lo=0; no later commit.
//  6. hi=0xA, lo=0xB, DIV rt=0 -> busy for 10 cycles; hi=0xA, lo=0xB after.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared MDU definitions used by the controller, mult_div_unit and mdu_arith.
//   - MDU op codes carried on the 3-bit mdu_op bus
//   - mdu_res_t: result bundle produced by the arithmetic datapath
//   - small op-class helper functions
package mult_div_unit_pkg;

   typedef logic [2:0] mdu_op_t;

   // Nine mnemonics have to share eight encodings. MDU_MFLO and MDU_NONE
   // share a code because both simply leave lo on mdu_out and change no state.
   localparam mdu_op_t MDU_NONE  = 3'd0;
   localparam mdu_op_t MDU_MFLO  = 3'd0;
   localparam mdu_op_t MDU_MULT  = 3'd1;
   localparam mdu_op_t MDU_MULTU = 3'd2;
   localparam mdu_op_t MDU_DIV   = 3'd3;
   localparam mdu_op_t MDU_DIVU  = 3'd4;
   localparam mdu_op_t MDU_MTHI  = 3'd5;
   localparam mdu_op_t MDU_MTLO  = 3'd6;
   localparam mdu_op_t MDU_MFHI  = 3'd7;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        div_zero;   // divide by zero: commit must leave hi/lo alone
   } mdu_res_t;

   // True for the multi-cycle ops that occupy the unit
   function automatic logic is_md_op(input mdu_op_t op);
      case (op)
         MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_md_op = 1'b1;
         default:                                is_md_op = 1'b0;
      endcase
   endfunction

   // True for the divide ops (they use the longer latency)
   function automatic logic is_div_op(input mdu_op_t op);
      case (op)
         MDU_DIV, MDU_DIVU: is_div_op = 1'b1;
         default:           is_div_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
//   Combinational arithmetic core of the MDU. Works on the operands latched
//   at launch, never on the live forwarded values.
// Ports
//   op   in   3   latched op code
//   a    in   32  latched rs operand (multiplicand / dividend)
//   b    in   32  latched rt operand (multiplier / divisor)
//   res  out  -   hi/lo result plus divide-by-zero flag
import mult_div_unit_pkg::*;

module mdu_arith (
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output mdu_res_t    res
);

   logic        signed_s;
   logic [63:0] a_ext_s;
   logic [63:0] b_ext_s;
   logic [63:0] prod_s;
   logic [31:0] mag_a_s;
   logic [31:0] mag_b_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;

   // Product and quotient/remainder for the latched op
   always_comb begin
      signed_s = (op == MDU_MULT) || (op == MDU_DIV);

      // The low 64 bits of a product of sign-extended operands are the signed product
      a_ext_s = signed_s ? {{32{a[31]}}, a} : {32'd0, a};
      b_ext_s = signed_s ? {{32{b[31]}}, b} : {32'd0, b};
      prod_s  = a_ext_s * b_ext_s;

      // Signed divide runs as an unsigned divide of magnitudes. That yields
      // truncation toward zero and handles 0x80000000 / -1 without overflow.
      mag_a_s = (signed_s && a[31]) ? (32'd0 - a) : a;
      mag_b_s = (signed_s && b[31]) ? (32'd0 - b) : b;
      if (b == 32'd0) begin
         quot_s = 32'd0;
         rem_s  = 32'd0;
      end else begin
         quot_s = mag_a_s / mag_b_s;
         rem_s  = mag_a_s % mag_b_s;
      end

      res.hi       = 32'd0;
      res.lo       = 32'd0;
      res.div_zero = 1'b0;
      case (op)
         MDU_MULT, MDU_MULTU: begin
            res.hi = prod_s[63:32];
            res.lo = prod_s[31:0];
         end
         MDU_DIV, MDU_DIVU: begin
            // The quotient is negative when the signs differ; the remainder follows the dividend
            res.lo       = (signed_s && (a[31] ^ b[31])) ? (32'd0 - quot_s) : quot_s;
            res.hi       = (signed_s && a[31]) ? (32'd0 - rem_s) : rem_s;
            res.div_zero = (b == 32'd0);
         end
         default: begin
            res.hi       = 32'd0;
            res.lo       = 32'd0;
            res.div_zero = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   E-stage multi-cycle multiply/divide unit. It owns the architectural HI/LO
//   registers. mult/multu/div/divu occupy the unit for a fixed number of
//   cycles. mthi/mtlo take one cycle, and mfhi/mflo are pure reads.
// Ports
//   clk      in   1   system clock
//   reset    in   1   synchronous active-high reset
//   start    in   1   E-stage instruction is mult/multu/div/divu
//   mdu_op   in   3   op code (mult_div_unit_pkg)
//   rs_val   in   32  forwarded rs operand
//   rt_val   in   32  forwarded rt operand
//   req      in   1   exception/interrupt taken; cancels this cycle's MDU instr
//   busy     out  1   operation in flight (register decode only)
//   hi       out  32  architectural HI
//   lo       out  32  architectural LO
//   mdu_out  out  32  hi for mfhi, otherwise lo
import mult_div_unit_pkg::*;

module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        req,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out
);

   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       op_r;
   logic [31:0]      a_r;
   logic [31:0]      b_r;
   mdu_res_t         res_r;
   mdu_res_t         arith_res_s;
   logic [31:0]      hi_r;
   logic [31:0]      lo_r;
   logic             busy_s;
   logic             launch_s;
   logic             commit_s;
   logic             mt_ok_s;

   // busy depends only on the counter register, so start/req have no path to it
   assign busy_s   = (cnt_r != {CNT_W{1'b0}});
   assign commit_s = (cnt_r == CNT_W'(1));
   assign launch_s = start && !busy_s && !req && is_md_op(mdu_op);
   assign mt_ok_s  = !busy_s && !req;

   mdu_arith u_arith (
      .op  (op_r),
      .a   (a_r),
      .b   (b_r),
      .res (arith_res_s)
   );

   // Cycle counter: loaded on launch, counts down to 0 while busy
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (launch_s) begin
         cnt_r <= is_div_op(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (busy_s) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Operand and op latch; held for the whole operation
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r <= MDU_NONE;
         a_r  <= 32'd0;
         b_r  <= 32'd0;
      end else if (launch_s) begin
         op_r <= mdu_op;
         a_r  <= rs_val;
         b_r  <= rt_val;
      end else begin
         op_r <= op_r;
         a_r  <= a_r;
         b_r  <= b_r;
      end
   end

   // Private result register. It is captured on every busy edge before the
   // commit edge, so the divider has at least one full cycle to settle.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_r <= '{hi: 32'd0, lo: 32'd0, div_zero: 1'b0};
      end else if (busy_s && !commit_s) begin
         res_r <= arith_res_s;
      end else begin
         res_r <= res_r;
      end
   end

   // Architectural HI/LO. A commit wins over mthi/mtlo. In practice both
   // cannot coincide, because busy is still high on the commit edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r <= 32'd0;
         lo_r <= 32'd0;
      end else if (commit_s) begin
         if (!res_r.div_zero) begin
            hi_r <= res_r.hi;
            lo_r <= res_r.lo;
         end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
         end
      end else if (mt_ok_s && (mdu_op == MDU_MTHI)) begin
         hi_r <= rs_val;
         lo_r <= lo_r;
      end else if (mt_ok_s && (mdu_op == MDU_MTLO)) begin
         hi_r <= hi_r;
         lo_r <= rs_val;
      end else begin
         hi_r <= hi_r;
         lo_r <= lo_r;
      end
   end

   assign busy    = busy_s;
   assign hi      = hi_r;
   assign lo      = lo_r;
   assign mdu_out = (mdu_op == MDU_MFHI) ? hi_r : lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. It uses directed scenarios plus
//   randomized operations, checked against a 64-bit arithmetic reference model.
import mult_div_unit_pkg::*;

module tb_mult_div_unit;

   localparam int EXP_MULT = 5;
   localparam int EXP_DIV  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        req;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mult_div_unit dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdu_op  (mdu_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .req     (req),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .mdu_out (mdu_out)
   );

   always #5 clk = ~clk;

   // Reference: architectural effect of one completed op, using 64-bit arithmetic
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      longint p;
      longint q;
      longint r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MDU_MULT:  begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
         MDU_MULTU: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
         MDU_DIV:   if (b != 32'd0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
         MDU_DIVU:  if (b != 32'd0) begin q = ua / ub; r = ua % ub; lo_m = q[31:0]; hi_m = r[31:0]; end
         default: ;
      endcase
   endfunction

   function automatic int exp_cycles(input logic [2:0] op);
      return ((op == MDU_DIV) || (op == MDU_DIVU)) ? EXP_DIV : EXP_MULT;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an MDU op for one edge, then return the bus to idle
   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      mdu_op = op;
      rs_val = a;
      rt_val = b;
      tick();
      start  = 1'b0;
      mdu_op = MDU_NONE;
   endtask

   // Count cycles with busy high, with a fixed upper bound
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         cycles++;
         tick();
      end
   endtask

   task automatic check_hilo(input string name);
      checks++;
      if (hi !== hi_m) begin
         errors++;
         $display("FAIL %s_hi got %h exp %h", name, hi, hi_m);
      end
      checks++;
      if (lo !== lo_m) begin
         errors++;
         $display("FAIL %s_lo got %h exp %h", name, lo, lo_m);
      end
   endtask

   task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int c;
      launch(op, a, b);
      wait_idle(c);
      model(op, a, b);
      checks++;
      if (c != exp_cycles(op)) begin
         errors++;
         $display("FAIL %s_cycles got %0d exp %0d", name, c, exp_cycles(op));
      end
      check_hilo(name);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      hi_m = 32'd0;
      lo_m = 32'd0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      check_hilo("reset");
      checks++;
      if (mdu_out !== 32'd0) begin errors++; $display("FAIL reset_out got %h exp 0", mdu_out); end
   endtask

   task automatic test_mult();
      run_check("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5);
      run_check("multu_big", MDU_MULTU, 32'hFFFF_FFFD, 32'd5);
      run_check("mult_minmin", MDU_MULT, 32'h8000_0000, 32'h8000_0000);
   endtask

   task automatic test_div();
      run_check("divu_7_2", MDU_DIVU, 32'd7, 32'd2);
      run_check("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      run_check("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE);
      run_check("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_mt_mf();
      mdu_op = MDU_MTHI;
      rs_val = 32'h0000_1234;
      tick();
      hi_m = 32'h0000_1234;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
      check_hilo("mthi");
      mdu_op = MDU_MFHI;
      #1;
      checks++;
      if (mdu_out !== 32'h0000_1234) begin errors++; $display("FAIL mfhi_out got %h exp 00001234", mdu_out); end
      mdu_op = MDU_MTLO;
      rs_val = 32'hCAFE_0001;
      tick();
      lo_m = 32'hCAFE_0001;
      check_hilo("mtlo");
      mdu_op = MDU_MFLO;
      #1;
      checks++;
      if (mdu_out !== lo_m) begin errors++; $display("FAIL mflo_out got %h exp %h", mdu_out, lo_m); end
   endtask

   task automatic test_req();
      int c;
      // A cancelled launch and a cancelled mtlo must leave no trace
      req = 1'b1;
      launch(MDU_MULT, 32'd9, 32'd9);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL req_launch_busy got %b exp 0", busy); end
      mdu_op = MDU_MTLO;
      rs_val = 32'h5555_5555;
      tick();
      mdu_op = MDU_NONE;
      req = 1'b0;
      check_hilo("req_block");
      // req arriving mid-operation does not cancel it
      launch(MDU_MULT, 32'd1000, 32'hFFFF_FF00);
      tick();
      req = 1'b1;
      tick();
      req = 1'b0;
      wait_idle(c);
      model(MDU_MULT, 32'd1000, 32'hFFFF_FF00);
      checks++;
      if (c + 2 != EXP_MULT) begin errors++; $display("FAIL req_mid_cycles got %0d exp %0d", c + 2, EXP_MULT); end
      check_hilo("req_mid");
   endtask

   task automatic test_ignore_busy();
      int c;
      launch(MDU_MULT, 32'd3, 32'd4);
      start  = 1'b1;
      mdu_op = MDU_DIV;
      rs_val = 32'd100;
      rt_val = 32'd3;
      tick();
      start  = 1'b0;
      mdu_op = MDU_MTHI;
      rs_val = 32'h7777_7777;
      tick();
      mdu_op = MDU_NONE;
      wait_idle(c);
      model(MDU_MULT, 32'd3, 32'd4);
      checks++;
      if (c + 2 != EXP_MULT) begin errors++; $display("FAIL ignore_cycles got %0d exp %0d", c + 2, EXP_MULT); end
      check_hilo("ignore");
   endtask

   task automatic test_reset_midop();
      launch(MDU_DIV, 32'd100, 32'd7);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hi_m = 32'd0;
      lo_m = 32'd0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
      check_hilo("rst_mid");
      repeat (12) tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_late_busy got %b exp 0", busy); end
      check_hilo("rst_late");
   endtask

   task automatic test_div_zero();
      mdu_op = MDU_MTHI;
      rs_val = 32'h0000_000A;
      tick();
      mdu_op = MDU_MTLO;
      rs_val = 32'h0000_000B;
      tick();
      hi_m = 32'h0000_000A;
      lo_m = 32'h0000_000B;
      run_check("div0", MDU_DIV, 32'd55, 32'd0);
      run_check("divu0", MDU_DIVU, 32'hFFFF_FFFF, 32'd0);
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ops [4];
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      ops[0] = MDU_MULT;
      ops[1] = MDU_MULTU;
      ops[2] = MDU_DIV;
      ops[3] = MDU_DIVU;
      for (int i = 0; i < 30; i++) begin
         op = ops[$urandom_range(0, 3)];
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         run_check("rand", op, a, b);
         mdu_op = MDU_MFHI;
         #1;
         checks++;
         if (mdu_out !== hi_m) begin errors++; $display("FAIL rand_mfhi got %h exp %h", mdu_out, hi_m); end
         mdu_op = MDU_NONE;
      end
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      req    = 1'b0;
      mdu_op = MDU_NONE;
      rs_val = 32'd0;
      rt_val = 32'd0;
      test_reset();
      test_mult();
      test_div();
      test_mt_mf();
      test_req();
      test_ignore_busy();
      test_reset_midop();
      test_div_zero();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
